// File: rtl/load_unit_if.sv
// -----------------------------------------------------------------------------
// load_unit_if.sv
// Bus bundles for the RV32I data-memory load unit.
//
// load_unit_req_if : request/response channel between the execute/memory stage
//                    (master) and the load unit (slave).
//   req_valid  m->s  load request present
//   req_ready  s->m  unit can accept a request
//   req_addr   m->s  byte address
//   req_funct3 m->s  load width/sign encoding
//   req_rd     m->s  destination register
//   rsp_valid  s->m  result available
//   rsp_ready  m->s  consumer accepts result
//   rsp_data   s->m  extended load result
//   rsp_rd     s->m  echoed destination register
//   rsp_err    s->m  misaligned / illegal / timeout
//
// load_unit_mem_if : request/grant/response memory read port, load unit is the
//                    master, data memory is the slave.
//   mem_req    m->s  read request, held until granted
//   mem_addr   m->s  word-aligned address
//   mem_gnt    s->m  request accepted this cycle
//   mem_rvalid s->m  read data valid
//   mem_rdata  s->m  read word, little-endian
// -----------------------------------------------------------------------------
interface load_unit_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_funct3, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err
  );
endinterface

interface load_unit_mem_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit.sv
// Data-memory load unit for the RV32I core. Accepts one load at a time, reads
// the containing 32-bit word over a request/grant/response port, then extracts
// and sign/zero-extends the addressed byte, halfword or word. Misaligned
// addresses, illegal funct3 encodings and memory timeouts return rsp_err=1
// with rsp_data=0.
//
// Parameters
//   TIMEOUT_CYCLES  cycles waited in WAIT for mem_rvalid before erroring
//                   (1..1023)
// Ports
//   clk     in   clock, all state on rising edge
//   rst_n   in   asynchronous active-low reset
//   req_if  slave  request/response channel (load_unit_req_if)
//   mem_if  master memory read port        (load_unit_mem_if)
//
// Every output is either a register or a decode of the state register, so no
// input reaches an output combinationally.
// -----------------------------------------------------------------------------
module load_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  load_unit_req_if.slave  req_if,
  load_unit_mem_if.master mem_if
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT_CYCLES);

  // Select the addressed lane of a little-endian word and extend it
  // according to the load encoding. Illegal encodings yield zero.
  function automatic logic [31:0] extract_load(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [2:0]  funct3
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'd0;
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      F3_LH:   res_v = {{16{half_v[15]}}, half_v};
      F3_LW:   res_v = word;
      F3_LBU:  res_v = {24'd0, byte_v};
      F3_LHU:  res_v = {16'd0, half_v};
      default: res_v = 32'd0;
    endcase
    return res_v;
  endfunction

  logic [1:0]  r_state;
  logic [9:0]  r_cnt;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [31:0] r_mem_addr;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_req_bad;
  logic [31:0] w_load_data;

  // Decode the incoming request: illegal encoding or misaligned access.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    case (req_if.req_funct3)
      F3_LB, F3_LBU: begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
      end
      F3_LH, F3_LHU: begin
        w_illegal    = 1'b0;
        w_misaligned = req_if.req_addr[0];
      end
      F3_LW: begin
        w_illegal    = 1'b0;
        w_misaligned = (req_if.req_addr[1:0] != 2'b00);
      end
      default: begin
        w_illegal    = 1'b1;
        w_misaligned = 1'b0;
      end
    endcase
    w_req_bad = w_illegal | w_misaligned;
  end

  // Aligned/extended result of the word currently on the memory read bus.
  always_comb begin
    w_load_data = extract_load(mem_if.mem_rdata, r_lane, r_funct3);
  end

  // Control FSM plus captured request and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 10'd0;
      r_lane     <= 2'd0;
      r_funct3   <= 3'd0;
      r_rd       <= 5'd0;
      r_mem_addr <= 32'd0;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_if.req_valid) begin
            r_lane   <= req_if.req_addr[1:0];
            r_funct3 <= req_if.req_funct3;
            r_rd     <= req_if.req_rd;
            if (w_req_bad) begin
              // Decode errors answer immediately without touching memory.
              r_rsp_err  <= 1'b1;
              r_rsp_data <= 32'd0;
              r_state    <= S_RESP;
            end else begin
              r_mem_addr <= {req_if.req_addr[31:2], 2'b00};
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_if.mem_gnt) begin
            r_cnt   <= 10'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_if.mem_rvalid) begin
            r_rsp_data <= w_load_data;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (r_cnt == TO_LIMIT) begin
            // Counter has reached the limit: give up and report an error.
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        S_RESP: begin
          if (req_if.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready = (r_state == S_IDLE);
  assign req_if.rsp_valid = (r_state == S_RESP);
  assign req_if.rsp_data  = r_rsp_data;
  assign req_if.rsp_rd    = r_rd;
  assign req_if.rsp_err   = r_rsp_err;
  assign mem_if.mem_req   = (r_state == S_ISSUE);
  assign mem_if.mem_addr  = r_mem_addr;

endmodule

// File: doc/load_unit.md
# load_unit

Data-memory load unit for the RV32I core: accepts one load request at a time from the execute/memory stage, fetches the containing 32-bit word over a request/grant/response memory interface, then extracts, aligns and sign/zero-extends the addressed byte, halfword or word. It is the read-side counterpart to the core's enabled-register writes: it produces the value that is later written into the register file at `rd`. It also flags misaligned addresses, illegal load encodings and memory timeouts.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles waiting in WAIT for `mem_rvalid` before erroring (1..1023)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  load request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_addr`  in  32  byte address
- `req_funct3`  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- `req_rd`  in  5  destination register, returned unchanged
- `mem_req`  out  1  memory read request, held until granted
- `mem_addr`  out  32  word address: `{addr[31:2], 2'b00}`
- `mem_gnt`  in  1  memory accepted request this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read word, little-endian
- `rsp_valid`  out  1  result available, held until `rsp_ready`
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  32  extended load result (0 on error)
- `rsp_rd`  out  5  captured `req_rd`
- `rsp_err`  out  1  misaligned, illegal funct3 or timeout

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: capture addr, funct3, rd. If illegal funct3 or misaligned (LH/LHU `addr[0]`=1; LW `addr[1:0]`≠0) -> RESP with `rsp_err`=1, `rsp_data`=0, no memory access. Else -> ISSUE.
- ISSUE: `mem_req`=1, `mem_addr` stable. `mem_gnt`=1 -> WAIT, timeout counter cleared to 0.
- WAIT: `mem_req`=0. `mem_rvalid`=1 -> capture extracted result, RESP, `rsp_err`=0. Else counter increments; when counter reaches `TIMEOUT_CYCLES` -> RESP with `rsp_err`=1, `rsp_data`=0.
- RESP: `rsp_valid`=1, data/rd/err stable. `rsp_ready`=1 -> IDLE.
- Extraction, lane = `addr[1:0]`: LB/LBU byte `rdata[8*lane +: 8]`, LH/LHU halfword `rdata[16*addr[1] +: 16]`; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes word.
- `mem_rvalid` outside WAIT ignored (late responses after timeout are dropped; memory must not produce them in normal use). `mem_gnt` outside ISSUE ignored.
- `mem_rvalid` in the same cycle as `mem_gnt` is not accepted; response must come at least one cycle later.

## Timing
- Reset: state IDLE; `req_ready`=1 after reset deasserts (combinational from state), `mem_req`=0, `mem_addr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_rd`=0, `rsp_err`=0, counter 0.
- Reset mid-operation aborts the transaction instantly; no response produced.
- All outputs registered or decoded from state only; no combinational path from any input to any output.
- Minimum latency, accept at edge 0 with gnt and rvalid each in first possible cycle: `mem_req` high cycle 1, `rsp_valid` high from cycle 3.
- Error by decode: `rsp_valid` high from cycle 1.
- Throughput: one load per 4 cycles best case; next request accepted the cycle after `rsp_ready` handshake.
- Timeout: `rsp_valid` rises `TIMEOUT_CYCLES`+1 cycles after entering WAIT.

## Test plan
- LW addr 0x100, mem returns 0xDEADBEEF gnt/rvalid immediate -> `mem_addr`=0x100, `rsp_data`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` at cycle 3, `rsp_rd` echoed.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80112233 -> 0xFFFFFF80 and 0x00000080; LH addr 0x102 same word -> 0xFFFF8011; LHU -> 0x00008011.
- LW addr 0x102, LH addr 0x101, funct3 011 -> `rsp_err`=1, `rsp_data`=0, `mem_req` never asserted, `rsp_valid` at cycle 1.
- Gnt delayed 5 cycles, rvalid delayed 7, `rsp_ready` held low 4 cycles -> `mem_req`/`mem_addr` stable until gnt, outputs stable while stalled, `req_ready`=0 throughout.
- TIMEOUT_CYCLES=8, no rvalid -> `rsp_err`=1 after 9 WAIT cycles; later spurious rvalid in IDLE ignored, next LW completes correctly.
- `rst_n` pulsed low during WAIT -> all outputs to reset values immediately; subsequent LBU completes normally.
